// File: rtl/sr_window_mac_pkg.sv
// -----------------------------------------------------------------------------
// sr_window_mac_pkg
// Shared ParCNN sizing constants and helpers. Downstream activation/pooling
// stages import this package so their input widths track the MAC result
// width exactly.
// -----------------------------------------------------------------------------
package sr_window_mac_pkg;

  localparam int DEPTH_DEF    = 3;
  localparam int DATA_W_DEF   = 8;
  localparam int WEIGHT_W_DEF = 8;

  // Ceiling log2 usable in constant expressions; clog2_f(1) = 0.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (value > (32'sd1 <<< i)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Width of a DEPTH-term signed dot product of unsigned taps and signed
  // weights; wide enough that the sum can never overflow.
  function automatic int out_width(input int data_w, input int weight_w,
                                   input int depth);
    return data_w + weight_w + clog2_f(depth);
  endfunction

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return clog2_f(depth + 1);
  endfunction

endpackage

// File: rtl/sr_window_mac_window_adder_tree.sv
// -----------------------------------------------------------------------------
// sr_window_mac_window_adder_tree
// Registered signed sum of DEPTH signed products. Reused by pooling and 2-D
// convolution stages.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low reset
//   in_valid  products bus holds a valid set of terms this cycle
//   products  DEPTH signed terms of IN_W bits, packed
//   out_valid registered copy of in_valid
//   sum       registered sign-extended sum; holds while out_valid is low
// -----------------------------------------------------------------------------
module sr_window_mac_window_adder_tree
  import sr_window_mac_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int IN_W  = DATA_W_DEF + WEIGHT_W_DEF,
  localparam int SUM_W = IN_W + clog2_f(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DEPTH*IN_W-1:0]   products,
  output logic                    out_valid,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [SUM_W-1:0] sum_s;

  // Sign-extend every term to the full sum width before adding.
  always_comb begin
    sum_s = {SUM_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      sum_s = sum_s + SUM_W'(signed'(products[i*IN_W +: IN_W]));
    end
  end

  // Output register; the sum only updates on a valid set of terms.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      sum       <= {SUM_W{1'b0}};
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum <= sum_s;
      end else begin
        sum <= sum;
      end
    end
  end

endmodule

// File: rtl/sr_window_mac.sv
// -----------------------------------------------------------------------------
// sr_window_mac
// Two-stage multiply-accumulate over the sliding-window tap bus. Produces one
// signed dot product per fully populated window once DEPTH weights have been
// serially loaded.
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   window         DEPTH unsigned taps; MSB slice oldest, LSB slice newest
//   win_valid      window holds a newly shifted sample this cycle
//   frame_start    restart fill tracking
//   weight_load    shift weight_in into the weight store
//   weight_in      signed weight
//   weights_ready  DEPTH weights loaded since reset
//   result         signed dot product (holds while result_valid is low)
//   result_valid   one-cycle pulse per accepted window, 2 cycles after it
// -----------------------------------------------------------------------------
module sr_window_mac
  import sr_window_mac_pkg::*;
#(
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int WEIGHT_W = WEIGHT_W_DEF,
  localparam int OUT_W    = out_width(DATA_W, WEIGHT_W, DEPTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_W*DEPTH-1:0]    window,
  input  logic                       win_valid,
  input  logic                       frame_start,
  input  logic                       weight_load,
  input  logic signed [WEIGHT_W-1:0] weight_in,
  output logic                       weights_ready,
  output logic signed [OUT_W-1:0]    result,
  output logic                       result_valid
);

  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int CNT_W  = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WEIGHT_W*DEPTH-1:0] weights_r;
  logic [CNT_W-1:0]          load_cnt_r;
  logic [CNT_W-1:0]          load_next_s;
  logic                      weights_ready_r;
  logic [CNT_W-1:0]          fill_r;
  logic [CNT_W-1:0]          fill_next_s;
  logic                      accept_s;
  logic [PROD_W*DEPTH-1:0]   products_s;
  logic [PROD_W*DEPTH-1:0]   products_r;
  logic                      valid_s1_r;

  assign weights_ready = weights_ready_r;

  // Load counter saturates at DEPTH; the store itself keeps shifting.
  always_comb begin
    load_next_s = load_cnt_r;
    if (weight_load && (load_cnt_r != DEPTH_CNT)) begin
      load_next_s = load_cnt_r + CNT_W'(1);
    end else begin
      load_next_s = load_cnt_r;
    end
  end

  // Weight store shifts toward the MSB so the first-loaded weight ends up
  // paired with the oldest tap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      weights_r       <= {(WEIGHT_W*DEPTH){1'b0}};
      load_cnt_r      <= {CNT_W{1'b0}};
      weights_ready_r <= 1'b0;
    end else begin
      if (weight_load) begin
        weights_r <= {weights_r[WEIGHT_W*(DEPTH-1)-1:0], weight_in};
      end
      load_cnt_r      <= load_next_s;
      weights_ready_r <= (load_next_s == DEPTH_CNT);
    end
  end

  // Fill tracking; a sample arriving with frame_start is the new frame's first.
  always_comb begin
    fill_next_s = fill_r;
    if (frame_start) begin
      if (win_valid) begin
        fill_next_s = CNT_W'(1);
      end else begin
        fill_next_s = {CNT_W{1'b0}};
      end
    end else if (win_valid && (fill_r != DEPTH_CNT)) begin
      fill_next_s = fill_r + CNT_W'(1);
    end else begin
      fill_next_s = fill_r;
    end
  end

  // Acceptance uses the post-update fill count and the current weight state,
  // so a weight_load in this cycle only affects later windows.
  assign accept_s = win_valid && (fill_next_s == DEPTH_CNT) && weights_ready_r;

  // Fill counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_r <= {CNT_W{1'b0}};
    end else begin
      fill_r <= fill_next_s;
    end
  end

  // Per-tap multiply: unsigned tap zero-extended, weight sign-extended. The
  // true product always fits in PROD_W signed bits.
  for (genvar i = 0; i < DEPTH; i++) begin : g_mul
    logic signed [PROD_W-1:0] tap_ext_s;
    logic signed [PROD_W-1:0] wt_ext_s;
    assign tap_ext_s = signed'(PROD_W'(window[i*DATA_W +: DATA_W]));
    assign wt_ext_s  = PROD_W'(signed'(weights_r[i*WEIGHT_W +: WEIGHT_W]));
    assign products_s[i*PROD_W +: PROD_W] = tap_ext_s * wt_ext_s;
  end

  // Stage 1 product register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_s1_r <= 1'b0;
      products_r <= {(PROD_W*DEPTH){1'b0}};
    end else begin
      valid_s1_r <= accept_s;
      if (accept_s) begin
        products_r <= products_s;
      end
    end
  end

  sr_window_mac_window_adder_tree #(
    .DEPTH (DEPTH),
    .IN_W  (PROD_W)
  ) u_adder_tree (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (valid_s1_r),
    .products  (products_r),
    .out_valid (result_valid),
    .sum       (result)
  );

endmodule

// File: tb/tb_sr_window_mac.sv
// -----------------------------------------------------------------------------
// tb_sr_window_mac
// Directed table of per-cycle vectors with hand-computed expectations, plus
// hand-written sequences for reset-in-flight, early windows and frame fill.
// -----------------------------------------------------------------------------
module tb_sr_window_mac;

  logic               clock = 1'b0;
  logic               reset;
  logic [23:0]        window;
  logic               win_valid;
  logic               frame_start;
  logic               weight_load;
  logic signed [7:0]  weight_in;
  logic               weights_ready;
  logic signed [17:0] result;
  logic               result_valid;

  int checks = 0;
  int errors = 0;

  sr_window_mac dut (
    .clock         (clock),
    .reset         (reset),
    .window        (window),
    .win_valid     (win_valid),
    .frame_start   (frame_start),
    .weight_load   (weight_load),
    .weight_in     (weight_in),
    .weights_ready (weights_ready),
    .result        (result),
    .result_valid  (result_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              wv;
    logic              fs;
    logic              wl;
    logic [7:0]        t_old;
    logic [7:0]        t_mid;
    logic [7:0]        t_new;
    logic signed [7:0] wi;
    logic              exp_rv;
    int                exp_res;
    logic              exp_wr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wv, input logic fs, input logic wl,
                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic signed [7:0] wi,
                     input logic erv, input int eres, input logic ewr);
    vec_t v;
    v.wv = wv; v.fs = fs; v.wl = wl;
    v.t_old = a; v.t_mid = b; v.t_new = c; v.wi = wi;
    v.exp_rv = erv; v.exp_res = eres; v.exp_wr = ewr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic fs, input logic wl,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic signed [7:0] wi);
    win_valid   = wv;
    frame_start = fs;
    weight_load = wl;
    window      = {a, b, c};
    weight_in   = wi;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'sd0);
  endtask

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic erv, input int eres);
    chk({tag, "_rv"}, result_valid, erv);
    chk({tag, "_res"}, result, eres);
  endtask

  logic [17:0] res_bits;

  initial begin
    reset = 1'b0;
    idle();

    // Weights 1,2,3 -> store {1,2,3}; later a load of 10 mid-stream.
    add(0,0,1,   0,  0,  0,  1, 0,    0, 0);
    add(0,0,1,   0,  0,  0,  2, 0,    0, 0);
    add(0,0,1,   0,  0,  0,  3, 0,    0, 1);
    add(1,1,0,   9,  9,  9,  0, 0,    0, 1);  // fill 1
    add(1,0,0,   9,  9,  9,  0, 0,    0, 1);  // fill 2
    add(1,0,0,   0,  1,  2,  0, 0,    0, 1);  // accept -> 8
    add(1,0,0,   1,  2,  3,  0, 1,    8, 1);  // accept -> 14
    add(0,0,0,   0,  0,  0,  0, 1,   14, 1);
    add(0,0,0,   0,  0,  0,  0, 0,   14, 1);  // hold
    add(1,0,0, 255,255,255,  0, 0,   14, 1);  // accept -> 1530
    add(1,0,0, 255,  0,  0,  0, 1, 1530, 1);  // accept -> 255
    add(1,1,0,   1,  1,  1,  0, 1,  255, 1);  // frame_start: in-flight emerges
    add(1,0,0,   1,  1,  1,  0, 0,  255, 1);  // suppressed
    add(1,0,0,   2,  0,  1,  0, 0,  255, 1);  // accept -> 5
    add(0,0,0,   0,  0,  0,  0, 1,    5, 1);
    add(0,0,0,   0,  0,  0,  0, 0,    5, 1);
    add(0,1,0,   0,  0,  0,  0, 0,    5, 1);  // frame_start alone -> fill 0
    add(1,0,0,   1,  0,  0,  0, 0,    5, 1);
    add(1,0,0,   1,  0,  0,  0, 0,    5, 1);
    add(1,0,0,   3,  0,  0,  0, 0,    5, 1);  // accept -> 3
    add(0,0,0,   0,  0,  0,  0, 1,    3, 1);
    add(0,0,0,   0,  0,  0,  0, 0,    3, 1);
    add(1,0,1,   1,  1,  1, 10, 0,    3, 1);  // old weights -> 6
    add(1,0,0,   1,  1,  1,  0, 1,    6, 1);  // weights {2,3,10} -> 15
    add(0,0,0,   0,  0,  0,  0, 1,   15, 1);
    add(0,0,0,   0,  0,  0,  0, 0,   15, 1);

    repeat (2) @(posedge clock);
    #1;
    chk_out("reset", 1'b0, 0);
    chk("reset_wr", weights_ready, 1'b0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].wv, vecs[i].fs, vecs[i].wl,
            vecs[i].t_old, vecs[i].t_mid, vecs[i].t_new, vecs[i].wi);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_res);
      chk($sformatf("vec%0d_wr", i), weights_ready, vecs[i].exp_wr);
    end

    // Reset with two windows in flight (weights {2,3,10}).
    drive(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 8'd1, 8'sd0);  // -> 15
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd1, 8'sd0);  // -> 10
    tick();
    chk_out("inflight", 1'b1, 15);
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 0);
    chk("async_rst_wr", weights_ready, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(i < 4, 1'b0, 1'b0, 8'd1, 8'd1, 8'd1, 8'sd0);
      tick();
      chk_out($sformatf("post_rst%0d", i), 1'b0, 0);
    end

    // Windows before weights_ready, weights -1,-1,-1; third load's window dropped.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'd255, 8'd255, 8'd255, -8'sd1);
      tick();
      chk_out($sformatf("early%0d", i), 1'b0, 0);
    end
    chk("early_wr", weights_ready, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255, 8'sd0);
    tick();
    chk_out("neg_s1", 1'b0, 0);
    idle();
    tick();
    chk_out("neg", 1'b1, -765);
    res_bits = result;
    chk("neg_bits", res_bits, 18'h3FD03);
    tick();
    chk_out("neg_hold", 1'b0, -765);

    // Reload 1,2,3 then fill a fresh frame with continuous win_valid.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'(i));
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd1, 8'sd0);
    tick();
    chk_out("fill1", 1'b0, -765);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 8'd0, 8'sd0);
    tick();
    chk_out("fill2", 1'b0, -765);
    drive(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 8'sd0);  // -> 1
    tick();
    chk_out("fill3", 1'b0, -765);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd2, 8'sd0);  // -> 6
    tick();
    chk_out("fill4", 1'b1, 1);
    idle();
    tick();
    chk_out("fill5", 1'b1, 6);
    tick();
    chk_out("fill6", 1'b0, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_window_mac.md
# sr_window_mac

Pipelined multiply-accumulate stage that consumes the parallel tap bus of the sliding-window shift register and produces one signed dot product per valid window. The kernel weights are held in an internal serially-loaded weight store. The block tracks window fill so that partially populated windows after reset or frame start never produce results. Throughput is one window per clock, and the block feeds the activation/pooling stages downstream.

## Interface
- DEPTH, 3, number of window taps and weights.
- DATA_W, 8, width of each tap; taps are unsigned.
- WEIGHT_W, 8, width of each weight; weights are signed two's complement.
- OUT_W (localparam), DATA_W+WEIGHT_W+$clog2(DEPTH), result width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- window  in  DATA_W*DEPTH  tap bus from the shift register; the MSB slice is the oldest sample and the LSB slice is the newest.
- win_valid  in  1  window holds a newly shifted sample this cycle.
- frame_start  in  1  restarts fill tracking; the window contents are stale.
- weight_load  in  1  shifts weight_in into the weight store this cycle.
- weight_in  in  WEIGHT_W  weight value, signed.
- weights_ready  out  1  DEPTH weights have been loaded since reset.
- result  out  OUT_W  signed dot product.
- result_valid  out  1  result is valid this cycle; single-cycle pulse per window.

## Operation
- **Reset.** All registers clear: result=0, result_valid=0, weights_ready=0, fill and load counters=0, weight store=0, pipeline valid bits=0.
- **Weight store:**
  - On weight_load, the store shifts toward the MSB and weight_in enters the LSB slice. After DEPTH loads, the first-loaded weight sits in the MSB slice and pairs with the oldest tap.
  - The load counter saturates at DEPTH. weights_ready=1 when the count equals DEPTH, and stays 1 across further loads (the store keeps shifting).
- **Fill counter:**
  - Increments on win_valid and saturates at DEPTH.
  - frame_start clears it. If frame_start and win_valid occur in the same cycle, the count becomes 1, so that sample counts as the first of the new frame.
- **Window acceptance.** A window is accepted in cycle N when all of the following hold: win_valid=1, the counter value after this cycle's update equals DEPTH, and weights_ready=1.
  - Windows that fail any condition are silently dropped. They still advance the fill counter.
- **Stage 1 (edge ending cycle N):**
  - Each tap i is zero-extended to DATA_W+1 bits and multiplied signed by weight i, giving a DATA_W+WEIGHT_W-bit signed product.
  - All DEPTH products are registered with valid_s1.
  - The weights used are the store contents during cycle N. A weight_load in cycle N affects only later windows.
- **Stage 2 (edge ending cycle N+1):**
  - The signed sum of all products is formed at OUT_W bits, sign-extended, and registered into result with result_valid.
  - The OUT_W width guarantees no overflow; there is no saturation or wrap.
- **Holding behaviour.** result holds its last value while result_valid=0. The valid bits advance every cycle; there is no stall or backpressure.

## Timing
- Latency is 2 cycles: a window accepted in cycle N gives result_valid=1 in cycle N+2.
- Throughput is one result per cycle for back-to-back accepted windows.
- After frame_start with continuous win_valid, the first result appears 2 cycles after the DEPTH-th valid window. The DEPTH-1 windows before it produce nothing.
- Reset mid-operation clears in-flight valid bits immediately (asynchronously). No stale result_valid appears after reset release.
- frame_start does not flush the pipeline. Windows already accepted still complete.

## Structure
- The OUT_W derivation and the clog2 helper go in the shared ParCNN constants package, so downstream stages size their inputs identically.
- One sub-module, window_adder_tree: a registered signed sum of DEPTH products, parameterised by DEPTH and input width. Pooling and future 2-D convolution stages reuse it.
- The multipliers, weight store, counters and acceptance logic stay in the top module.

## Test plan
- Load weights 1, 2, 3. Drive windows {0,1,2} and then {1,2,3} with the fill counter already saturated. Expect result=8, then 14, on consecutive cycles, each 2 cycles after its window.
- Reset released, weights 1, 2, 3 loaded, win_valid high every cycle from frame_start. Expect no result_valid for the first two windows; the third window gives result_valid exactly 2 cycles later.
- Load weights -1, -1, -1 and drive window {255,255,255}. Expect result=-765 (18-bit two's complement 0x3FD03).
- Drive valid windows before weights_ready. Expect no result_valid. Once the third weight_load completes, the next valid window produces a result.
- Assert frame_start together with win_valid mid-stream. Expect in-flight results to still emerge, then exactly DEPTH-1 suppressed windows before output resumes.
- Assert reset while two windows are in flight. Expect result_valid=0 and result=0 immediately, weights_ready=0, and no pulses after release until a full reload and refill.
